// File: rtl/rom_seq_pkg.sv
// Shared types and default widths for the ROM sequencer.
// Holds the RUN/HALTED state encoding used by rom_sequencer.
package rom_seq_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } seq_state_t;

endpackage

// File: rtl/rom_seq_pc.sv
// Program counter: sync reset to RESET_PC, load, or +1 (wraps).
// Ports: clk, reset, load, target, inc -> pc.
module rom_seq_pc
  import rom_seq_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] target,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clk) begin
    if (reset)
      pc <= ADDR_W'(RESET_PC);
    else if (load)
      pc <= target;
    else if (inc)
      pc <= pc + 1'b1;
  end

endmodule

// File: rtl/rom_sequencer.sv
// ROM fetch sequencer: valid/ready instr output, jump, halt/resume.
// Ports: clk, reset, rom_address/rom_data, instr/instr_valid/instr_ready,
//   jump/jump_target, halt, resume, pc, halted.
// Option SEQ_BREAKPOINT_EN adds bp_en/bp_addr (halt before fetch at bp_addr).
module rom_sequencer
  import rom_seq_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              halt,
  input  logic              resume,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
`ifdef SEQ_BREAKPOINT_EN
  ,
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_addr
`endif
);

  seq_state_t        state, state_n;
  logic [DATA_W-1:0] instr_n;
  logic              valid_n;
  logic              pc_load;
  logic              pc_inc;
  logic              bp_hit;

`ifdef SEQ_BREAKPOINT_EN
  // Set on resume so the first fetch steps over the breakpoint.
  logic skip_bp, skip_bp_n;

  assign bp_hit = bp_en && (pc == bp_addr) && !skip_bp;

  always_ff @(posedge clk) begin
    if (reset)
      skip_bp <= 1'b0;
    else
      skip_bp <= skip_bp_n;
  end

  always_comb begin
    skip_bp_n = skip_bp;
    if (state == HALTED && resume && !halt)
      skip_bp_n = 1'b1;
    else if (pc_inc)
      skip_bp_n = 1'b0;
  end
`else
  assign bp_hit = 1'b0;
`endif

  assign rom_address = pc;
  assign halted      = (state == HALTED);

  rom_seq_pc #(
    .ADDR_W  (ADDR_W),
    .RESET_PC(RESET_PC)
  ) u_pc (
    .clk   (clk),
    .reset (reset),
    .load  (pc_load),
    .target(jump_target),
    .inc   (pc_inc),
    .pc    (pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      instr       <= '0;
      instr_valid <= 1'b0;
    end else begin
      state       <= state_n;
      instr       <= instr_n;
      instr_valid <= valid_n;
    end
  end

  always_comb begin
    state_n = state;
    instr_n = instr;
    valid_n = instr_valid;
    pc_load = 1'b0;
    pc_inc  = 1'b0;
    if (halt) begin
      state_n = HALTED;
      valid_n = 1'b0;
    end else if (state == RUN) begin
      if (jump) begin
        pc_load = 1'b1;
        valid_n = 1'b0;
      end else if (!instr_valid || instr_ready) begin
        if (bp_hit) begin
          state_n = HALTED;
          valid_n = 1'b0;
        end else begin
          instr_n = rom_data;
          valid_n = 1'b1;
          pc_inc  = 1'b1;
        end
      end
    end else begin
      valid_n = 1'b0;
      pc_load = jump;
      if (resume)
        state_n = RUN;
    end
  end

endmodule

// File: tb/tb_rom_sequencer.sv
// Directed self-checking bench for rom_sequencer.
// Breakpoint checks run only when built with SEQ_BREAKPOINT_EN.
module tb_rom_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rom_address;
  logic [7:0] rom_data;
  logic [7:0] instr;
  logic       instr_valid;
  logic       instr_ready;
  logic       jump;
  logic [7:0] jump_target;
  logic       halt;
  logic       resume;
  logic [7:0] pc;
  logic       halted;
`ifdef SEQ_BREAKPOINT_EN
  logic       bp_en;
  logic [7:0] bp_addr;
`endif

  logic [7:0] rom [0:255];
  int n_chk  = 0;
  int n_fail = 0;

  assign rom_data = rom[rom_address];

  always #5 clk = ~clk;

  rom_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .rom_address(rom_address),
    .rom_data   (rom_data),
    .instr      (instr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .jump       (jump),
    .jump_target(jump_target),
    .halt       (halt),
    .resume     (resume),
    .pc         (pc),
    .halted     (halted)
`ifdef SEQ_BREAKPOINT_EN
    ,
    .bp_en      (bp_en),
    .bp_addr    (bp_addr)
`endif
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic st(input string tag,
                    input logic [7:0] e_pc,
                    input logic       e_v,
                    input logic       e_h);
    chk({tag, ".pc"}, 32'(pc), 32'(e_pc));
    chk({tag, ".valid"}, 32'(instr_valid), 32'(e_v));
    chk({tag, ".halted"}, 32'(halted), 32'(e_h));
  endtask

  initial begin
    for (int i = 0; i < 256; i++)
      rom[i] = 8'(i * 3 + 7);
    rom[0] = 8'hB1;
    rom[1] = 8'h0A;
    rom[4] = 8'h44;
    reset = 1'b1; instr_ready = 1'b1; jump = 1'b0;
    jump_target = 8'h00; halt = 1'b0; resume = 1'b0;
`ifdef SEQ_BREAKPOINT_EN
    bp_en = 1'b0; bp_addr = 8'h00;
`endif
    step(); step();
    st("rst", 8'h00, 1'b0, 1'b0);
    chk("rst.instr", 32'(instr), 32'h0);
    chk("rst.addr", 32'(rom_address), 32'h0);

    // Streaming fetch, ready held high
    reset = 1'b0;
    step();
    chk("f1.instr", 32'(instr), 32'hB1);
    st("f1", 8'h01, 1'b1, 1'b0);
    step();
    chk("f2.instr", 32'(instr), 32'h0A);
    st("f2", 8'h02, 1'b1, 1'b0);

    // Backpressure: hold 0xB1 for three cycles
    reset = 1'b1; step();
    reset = 1'b0; instr_ready = 1'b0;
    step();
    chk("bp0.instr", 32'(instr), 32'hB1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold.instr", 32'(instr), 32'hB1);
      st("hold", 8'h01, 1'b1, 1'b0);
    end
    instr_ready = 1'b1;
    step();
    chk("rel.instr", 32'(instr), 32'h0A);
    st("rel", 8'h02, 1'b1, 1'b0);

    // Jump while instr valid and not ready
    instr_ready = 1'b0; jump = 1'b1; jump_target = 8'h04;
    step();
    st("jmp", 8'h04, 1'b0, 1'b0);
    jump = 1'b0;
    step();
    chk("jmp.instr", 32'(instr), 32'h44);
    st("jmp2", 8'h05, 1'b1, 1'b0);

    // PC wrap from 0xFF
    instr_ready = 1'b1; jump = 1'b1; jump_target = 8'hFF;
    step();
    st("toff", 8'hFF, 1'b0, 1'b0);
    jump = 1'b0;
    step();
    chk("wrap.instr", 32'(instr), 32'(rom[255]));
    st("wrap", 8'h00, 1'b1, 1'b0);
    step();
    chk("wrap2.instr", 32'(instr), 32'hB1);
    st("wrap2", 8'h01, 1'b1, 1'b0);

    // Resume in RUN is a no-op
    resume = 1'b1;
    step();
    resume = 1'b0;
    chk("rrun.instr", 32'(instr), 32'h0A);
    st("rrun", 8'h02, 1'b1, 1'b0);

    // Halt beats jump
    halt = 1'b1; jump = 1'b1; jump_target = 8'h40;
    step();
    halt = 1'b0; jump = 1'b0;
    st("hj", 8'h02, 1'b0, 1'b1);
    step();
    st("hstay", 8'h02, 1'b0, 1'b1);
    jump = 1'b1; jump_target = 8'h10;
    step();
    jump = 1'b0;
    st("hjmp", 8'h10, 1'b0, 1'b1);
    resume = 1'b1;
    step();
    resume = 1'b0;
    st("res", 8'h10, 1'b0, 1'b0);
    step();
    chk("res.instr", 32'(instr), 32'(rom[16]));
    st("res2", 8'h11, 1'b1, 1'b0);

    // Reset while halted
    halt = 1'b1; step(); halt = 1'b0;
    chk("h2", 32'(halted), 32'h1);
    reset = 1'b1; step();
    st("hrst", 8'h00, 1'b0, 1'b0);
    chk("hrst.instr", 32'(instr), 32'h0);
    reset = 1'b0; step();
    chk("hrst2.instr", 32'(instr), 32'hB1);

`ifdef SEQ_BREAKPOINT_EN
    reset = 1'b1; step();
    reset = 1'b0; bp_en = 1'b1; bp_addr = 8'h02;
    step(); step();
    chk("bpf.instr", 32'(instr), 32'h0A);
    step();
    st("bphit", 8'h02, 1'b0, 1'b1);
    step();
    st("bpstay", 8'h02, 1'b0, 1'b1);
    resume = 1'b1; step(); resume = 1'b0;
    st("bpres", 8'h02, 1'b0, 1'b0);
    step();
    chk("bp.instr", 32'(instr), 32'(rom[2]));
    st("bpstep", 8'h03, 1'b1, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
